// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS datapath: sequential, branch,
// jump, return-address-stack return, trap redirect, and a stall on memory busywait.
module pc_sequencer #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'(32'h0000_0080),
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             busywait,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             trap,
  output logic [WIDTH-1:0] PC_data,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ret_err,
  output logic             misalign
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             trap_pend_q, trap_pend_d;
  logic             ovf_q, ovf_d;
  logic             ret_err_q, ret_err_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             ras_we;
  logic [PW-1:0]    ras_waddr;
  logic [WIDTH-1:0] target;
  logic             redirect;

  assign pc_plus4 = pc_q + WIDTH'(4);

  always_comb begin
    pc_d        = pc_q;
    top_d       = top_q;
    cnt_d       = cnt_q;
    trap_pend_d = trap_pend_q;
    ovf_d       = ovf_q;
    ret_err_d   = 1'b0;
    mis_d       = 1'b0;
    ras_we      = 1'b0;
    ras_waddr   = top_q + PW'(1);
    target      = pc_plus4;
    redirect    = 1'b0;

    if (busywait) begin
      // A trap arriving mid-stall is remembered and taken once the stall clears.
      trap_pend_d = trap_pend_q | trap;
    end else if (trap || trap_pend_q) begin
      pc_d        = TRAP_VEC;
      trap_pend_d = 1'b0;
    end else begin
      if (ret_en) begin
        if (cnt_q == '0) begin
          ret_err_d = 1'b1;
          if (call_en) begin
            ras_we = 1'b1;
            top_d  = top_q + PW'(1);
            cnt_d  = CW'(1);
          end
        end else begin
          target   = ras_q[top_q];
          redirect = 1'b1;
          // Return+call swaps the top slot in place instead of pop-then-push.
          if (call_en) begin
            ras_we    = 1'b1;
            ras_waddr = top_q;
          end else begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
      end else begin
        if (jump_en) begin
          target   = jump_target;
          redirect = 1'b1;
        end else if (branch_en) begin
          target   = pc_plus4 + branch_offset;
          redirect = 1'b1;
        end
        if (call_en) begin
          ras_we = 1'b1;
          top_d  = top_q + PW'(1);
          if (cnt_q == DEPTH_C) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CW'(1);
        end
      end

      if (redirect && (target[1:0] != 2'b00)) begin
        pc_d  = TRAP_VEC;
        mis_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q        <= RESET_ADDR;
      top_q       <= '0;
      cnt_q       <= '0;
      trap_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      ret_err_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      trap_pend_q <= trap_pend_d;
      ovf_q       <= ovf_d;
      ret_err_q   <= ret_err_d;
      mis_q       <= mis_d;
    end
  end

  // Stack storage is deliberately left uninitialised; count guards every read.
  always_ff @(posedge CLK) begin
    if (!RESET && ras_we) ras_q[ras_waddr] <= pc_plus4;
  end

  assign PC_data      = pc_q;
  assign ras_empty    = (cnt_q == '0);
  assign ras_full     = (cnt_q == DEPTH_C);
  assign ras_overflow = ovf_q;
  assign ret_err      = ret_err_q;
  assign misalign     = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_sequencer;
  localparam int W = 32;
  localparam int D = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET, busywait, branch_en, jump_en, call_en, ret_en, trap;
  logic [W-1:0] branch_offset, jump_target;
  logic [W-1:0] PC_data, pc_plus4;
  logic ras_empty, ras_full, ras_overflow, ret_err, misalign;

  logic rst8, z8;
  logic [7:0] v8, pc8, pp8;
  logic e8, f8, o8, r8, m8;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.WIDTH(W), .RESET_ADDR(32'h0), .TRAP_VEC(32'h80), .RAS_DEPTH(D)) u_dut (
    .CLK(CLK), .RESET(RESET), .busywait(busywait), .branch_en(branch_en),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_target(jump_target),
    .call_en(call_en), .ret_en(ret_en), .trap(trap), .PC_data(PC_data),
    .pc_plus4(pc_plus4), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ret_err(ret_err), .misalign(misalign)
  );

  pc_sequencer #(.WIDTH(8), .RESET_ADDR(8'hF0), .TRAP_VEC(8'h80), .RAS_DEPTH(2)) u_dut8 (
    .CLK(CLK), .RESET(rst8), .busywait(z8), .branch_en(z8), .branch_offset(v8),
    .jump_en(z8), .jump_target(v8), .call_en(z8), .ret_en(z8), .trap(z8),
    .PC_data(pc8), .pc_plus4(pp8), .ras_empty(e8), .ras_full(f8),
    .ras_overflow(o8), .ret_err(r8), .misalign(m8)
  );

  // Reference model: the stack is a bounded queue, oldest entry at the front.
  logic [W-1:0] m_pc;
  logic         m_tp, m_ovf, m_rerr, m_mis;
  logic [W-1:0] m_stack[$];

  task automatic model_push(input logic [W-1:0] v);
    if (m_stack.size() == D) begin
      void'(m_stack.pop_front());
      m_ovf = 1'b1;
    end
    m_stack.push_back(v);
  endtask

  task automatic model_step(input logic rst, bw, br, j, c, r, t,
                            input logic [W-1:0] off, tgt);
    logic [W-1:0] p4, nxt;
    logic sel;
    if (rst) begin
      m_pc = 32'h0; m_tp = 0; m_ovf = 0; m_rerr = 0; m_mis = 0;
      m_stack.delete();
      return;
    end
    m_rerr = 0; m_mis = 0;
    if (bw) begin
      m_tp = m_tp | t;
      return;
    end
    if (t || m_tp) begin
      m_pc = 32'h80; m_tp = 0;
      return;
    end
    p4 = m_pc + 4;
    nxt = p4;
    sel = 0;
    if (r) begin
      if (m_stack.size() == 0) begin
        m_rerr = 1;
        if (c) model_push(p4);
      end else begin
        nxt = m_stack[m_stack.size()-1];
        sel = 1;
        if (c) m_stack[m_stack.size()-1] = p4;
        else void'(m_stack.pop_back());
      end
    end else begin
      if (j) begin nxt = tgt; sel = 1; end
      else if (br) begin nxt = p4 + off; sel = 1; end
      if (c) model_push(p4);
    end
    if (sel && nxt[1:0] != 2'b00) begin
      m_mis = 1;
      nxt = 32'h80;
    end
    m_pc = nxt;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit past the edge.
  task automatic step(input logic rst, bw, br, j, c, r, t,
                      input logic [W-1:0] off, tgt);
    RESET = rst; busywait = bw; branch_en = br; jump_en = j; call_en = c;
    ret_en = r; trap = t; branch_offset = off; jump_target = tgt;
    model_step(rst, bw, br, j, c, r, t, off, tgt);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst8 = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PC_data, 32'h0); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
    checks++; if ({ras_empty, ras_full, ras_overflow, ret_err, misalign} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags: got %b want %b", {ras_empty, ras_full, ras_overflow, ret_err, misalign}, 5'b10000); end
    checks++; if (pc8 !== 8'hF0) begin errors++; $display("FAIL reset_pc8: got %h want %h", pc8, 8'hF0); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      idle();
      checks++; if (PC_data !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC_data, 32'(4 * i)); end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL seq_empty[%0d]: got %b want 1", i, ras_empty); end
    end
  endtask

  task automatic test_branch_call_ret();
    idle();
    checks++; if (PC_data !== 32'h10) begin errors++; $display("FAIL bcr_start: got %h want %h", PC_data, 32'h10); end
    step(0, 0, 1, 0, 0, 0, 0, 32'h20, 32'h0);
    checks++; if (PC_data !== 32'h34) begin errors++; $display("FAIL branch_pc: got %h want %h", PC_data, 32'h34); end
    step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h100);
    checks++; if (PC_data !== 32'h100) begin errors++; $display("FAIL call_pc: got %h want %h", PC_data, 32'h100); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty: got %b want 0", ras_empty); end
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h38) begin errors++; $display("FAIL ret_pc: got %h want %h", PC_data, 32'h38); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_stall_trap();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 0, (i == 1), 32'h40, 32'h0);
      checks++; if (PC_data !== 32'h38) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, PC_data, 32'h38); end
    end
    step(0, 0, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    checks++; if (PC_data !== 32'h80) begin errors++; $display("FAIL stall_trap_pc: got %h want %h", PC_data, 32'h80); end
    idle();
    checks++; if (PC_data !== 32'h84) begin errors++; $display("FAIL trap_cleared_pc: got %h want %h", PC_data, 32'h84); end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h10);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'(32'h14 + 4 * i));
      checks++; if (ras_overflow !== (i == 4)) begin errors++; $display("FAIL ovf_push[%0d]: got %b want %b", i, ras_overflow, (i == 4)); end
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", ras_full); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      checks++; if (PC_data !== 32'(32'h24 - 4 * i)) begin errors++; $display("FAIL ovf_ret[%0d]: got %h want %h", i, PC_data, 32'(32'h24 - 4 * i)); end
    end
    checks++; if ({ras_empty, ras_overflow} !== 2'b11) begin errors++; $display("FAIL ovf_drained: got %b want 11", {ras_empty, ras_overflow}); end
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h1C) begin errors++; $display("FAIL empty_ret_pc: got %h want %h", PC_data, 32'h1C); end
    checks++; if (ret_err !== 1'b1) begin errors++; $display("FAIL empty_ret_err: got %b want 1", ret_err); end
    idle();
    checks++; if (ret_err !== 1'b0) begin errors++; $display("FAIL ret_err_pulse: got %b want 0", ret_err); end
  endtask

  task automatic test_misalign();
    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h102);
    checks++; if (PC_data !== 32'h80) begin errors++; $display("FAIL mis_pc: got %h want %h", PC_data, 32'h80); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", misalign); end
    idle();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misalign); end
  endtask

  task automatic test_ret_call();
    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h3C);
    step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h200);
    checks++; if (PC_data !== 32'h200) begin errors++; $display("FAIL rc_setup: got %h want %h", PC_data, 32'h200); end
    step(0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h40) begin errors++; $display("FAIL rc_pc: got %h want %h", PC_data, 32'h40); end
    checks++; if ({ras_empty, ras_full} !== 2'b00) begin errors++; $display("FAIL rc_count: got %b want 00", {ras_empty, ras_full}); end
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h204) begin errors++; $display("FAIL rc_swapped_top: got %h want %h", PC_data, 32'h204); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rc_empty: got %b want 1", ras_empty); end
    step(0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0);
    checks++; if ({ret_err, ras_empty} !== 2'b10) begin errors++; $display("FAIL rc_empty_err: got %b want 10", {ret_err, ras_empty}); end
    checks++; if (PC_data !== 32'h208) begin errors++; $display("FAIL rc_empty_pc: got %h want %h", PC_data, 32'h208); end
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h208) begin errors++; $display("FAIL rc_empty_push: got %h want %h", PC_data, 32'h208); end
  endtask

  task automatic test_reset_in_stall();
    step(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (PC_data !== 32'h0) begin errors++; $display("FAIL rst_stall_pc: got %h want %h", PC_data, 32'h0); end
    idle();
    checks++; if (PC_data !== 32'h4) begin errors++; $display("FAIL rst_aborts_trap: got %h want %h", PC_data, 32'h4); end
  endtask

  task automatic test_wrap8();
    rst8 = 1'b1;
    idle();
    rst8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idle();
      checks++; if (pc8 !== 8'(8'hF0 + 4 * i)) begin errors++; $display("FAIL wrap8_pc[%0d]: got %h want %h", i, pc8, 8'(8'hF0 + 4 * i)); end
      checks++; if (pp8 !== 8'(8'hF4 + 4 * i)) begin errors++; $display("FAIL wrap8_plus4[%0d]: got %h want %h", i, pp8, 8'(8'hF4 + 4 * i)); end
    end
    checks++; if ({e8, f8, o8, r8, m8} !== 5'b10000) begin errors++; $display("FAIL wrap8_flags: got %b want 10000", {e8, f8, o8, r8, m8}); end
  endtask

  task automatic test_random();
    logic rst, bw, br, j, c, r, t;
    logic [W-1:0] off, tgt;
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bw  = ($urandom_range(0, 4) == 0);
      t   = ($urandom_range(0, 19) == 0);
      br  = ($urandom_range(0, 3) == 0);
      j   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 3) == 0);
      off = W'($urandom_range(0, 255)) & ~W'(3);
      if ($urandom_range(0, 1) == 1) off = -off;
      tgt = W'($urandom_range(0, 4095)) & ~W'(3);
      if ($urandom_range(0, 9) == 0) off = off | W'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) tgt = tgt | W'($urandom_range(1, 3));
      step(rst, bw, br, j, c, r, t, off, tgt);
      checks++; if (PC_data !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, PC_data, m_pc); end
      checks++; if (pc_plus4 !== m_pc + 32'h4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h want %h", n, pc_plus4, m_pc + 32'h4); end
      checks++; if (ras_empty !== (m_stack.size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d]: got %b want %b", n, ras_empty, (m_stack.size() == 0)); end
      checks++; if (ras_full !== (m_stack.size() == D)) begin errors++; $display("FAIL rnd_full[%0d]: got %b want %b", n, ras_full, (m_stack.size() == D)); end
      checks++; if (ras_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, ras_overflow, m_ovf); end
      checks++; if (ret_err !== m_rerr) begin errors++; $display("FAIL rnd_ret_err[%0d]: got %b want %b", n, ret_err, m_rerr); end
      checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_misalign[%0d]: got %b want %b", n, misalign, m_mis); end
    end
  endtask

  initial begin
    z8 = 1'b0;
    v8 = 8'h0;
    rst8 = 1'b1;
    test_reset();
    test_sequential();
    test_branch_call_ret();
    test_stall_trap();
    test_overflow();
    test_misalign();
    test_ret_call();
    test_reset_in_stall();
    test_wrap8();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
